// File: rtl/mc_maindec.sv
// Multicycle MIPS main controller: 3-5 cycles per instruction, stalls in FETCH/MEMRD/MEMWR until mem_ready.
// Define MC_MAINDEC_TRAP_EN to trap on illegal opcodes and memory-wait timeouts; otherwise trap is tied 0.
module mc_maindec #(
    parameter int OPW    = 6,
    parameter int FUNCTW = 6,
    parameter int CNTW   = 32
`ifdef MC_MAINDEC_TRAP_EN
    ,
    parameter int TMOW   = 4
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OPW-1:0]    op,
    input  logic [FUNCTW-1:0] funct,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              memwrite,
    output logic              irwrite,
    output logic              iord,
    output logic              regwrite,
    output logic [1:0]        regdst,
    output logic [1:0]        memtoreg,
    output logic              alusrca,
    output logic [1:0]        alusrcb,
    output logic [1:0]        aluop,
    output logic [1:0]        pcsrc,
    output logic              pcen,
    output logic [3:0]        state,
    output logic [CNTW-1:0]   instret,
    output logic              trap
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_IEXEC  = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13,
        S_TRAP   = 4'd15
    } state_t;

    localparam logic [OPW-1:0]    OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0]    OP_LW    = OPW'(6'b000001);
    localparam logic [OPW-1:0]    OP_SW    = OPW'(6'b000010);
    localparam logic [OPW-1:0]    OP_ADDI  = OPW'(6'b000011);
    localparam logic [OPW-1:0]    OP_SUBI  = OPW'(6'b000100);
    localparam logic [OPW-1:0]    OP_BEQ   = OPW'(6'b000101);
    localparam logic [OPW-1:0]    OP_BNE   = OPW'(6'b001001);
    localparam logic [OPW-1:0]    OP_J     = OPW'(6'b000111);
    localparam logic [OPW-1:0]    OP_JAL   = OPW'(6'b001000);
    localparam logic [FUNCTW-1:0] FN_JR    = FUNCTW'(6'b000111);

`ifdef MC_MAINDEC_TRAP_EN
    localparam state_t           ILLEGAL_DEST = S_TRAP;
    // Trap on the edge that would bring the wait count to all-ones.
    localparam logic [TMOW-1:0]  TMO_LAST     = {TMOW{1'b1}} - TMOW'(1);
    logic [TMOW-1:0] tmo_q;
    logic            trap_q;
    logic            in_mem_state;
`else
    localparam state_t           ILLEGAL_DEST = S_FETCH;
`endif

    state_t state_q;
    state_t state_nxt;
    logic   pcwrite;
    logic   branch;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:     state_nxt = S_MEMADR;
                    OP_RTYPE:         state_nxt = (funct == FN_JR) ? S_JR : S_EXEC;
                    OP_ADDI, OP_SUBI: state_nxt = S_IEXEC;
                    OP_BEQ, OP_BNE:   state_nxt = S_BRANCH;
                    OP_J:             state_nxt = S_JUMP;
                    OP_JAL:           state_nxt = S_JAL;
                    default:          state_nxt = ILLEGAL_DEST;
                endcase
            end
            S_MEMADR: state_nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_nxt = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_nxt = S_FETCH;
            S_EXEC:   state_nxt = S_ALUWB;
            S_IEXEC:  state_nxt = S_IWB;
            S_MEMWB, S_ALUWB, S_IWB, S_BRANCH, S_JUMP, S_JAL, S_JR:
                      state_nxt = S_FETCH;
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_FETCH;
        endcase
`ifdef MC_MAINDEC_TRAP_EN
        if (in_mem_state && !mem_ready && tmo_q == TMO_LAST) state_nxt = S_TRAP;
`endif
    end

    // Enables are suppressed during reset so an aborted access cannot fire.
    always_comb begin
        mem_req  = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        iord     = 1'b0;
        regwrite = 1'b0;
        regdst   = 2'b00;
        memtoreg = 2'b00;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = 2'b00;
        pcsrc    = 2'b00;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    alusrcb = 2'b01;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                S_DECODE: alusrcb = 2'b11;
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWR: begin
                    mem_req  = 1'b1;
                    iord     = 1'b1;
                    memwrite = mem_ready;
                end
                S_MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 2'b01;
                end
                S_EXEC: begin
                    alusrca = 1'b1;
                    aluop   = 2'b10;
                end
                S_ALUWB: begin
                    regwrite = 1'b1;
                    regdst   = 2'b01;
                end
                S_IEXEC: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    aluop   = (op == OP_SUBI) ? 2'b01 : 2'b00;
                end
                S_IWB:    regwrite = 1'b1;
                S_BRANCH: begin
                    alusrca = 1'b1;
                    branch  = 1'b1;
                    pcsrc   = 2'b01;
                    aluop   = (op == OP_BNE) ? 2'b11 : 2'b01;
                end
                S_JUMP: begin
                    pcwrite = 1'b1;
                    pcsrc   = 2'b10;
                end
                S_JAL: begin
                    pcwrite  = 1'b1;
                    pcsrc    = 2'b10;
                    regwrite = 1'b1;
                    regdst   = 2'b10;
                    memtoreg = 2'b10;
                end
                S_JR: begin
                    pcwrite = 1'b1;
                    pcsrc   = 2'b11;
                end
                default: ;
            endcase
        end
        pcen = pcwrite | (branch & (zero ^ (aluop == 2'b11)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            instret <= '0;
        end else begin
            state_q <= state_nxt;
            if (state_nxt == S_FETCH && state_q != S_FETCH && state_q != S_TRAP)
                instret <= instret + CNTW'(1);
        end
    end

    assign state = state_q;

`ifdef MC_MAINDEC_TRAP_EN
    assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q  <= '0;
            trap_q <= 1'b0;
        end else begin
            if (state_nxt != state_q)
                tmo_q <= '0;
            else if (in_mem_state && !mem_ready)
                tmo_q <= tmo_q + TMOW'(1);
            if (state_nxt == S_TRAP)
                trap_q <= 1'b1;
        end
    end

    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

endmodule
